// File: rtl/rr_resource_scheduler.sv
// Round-robin scheduler sharing one downstream resource among N requesters.
// A grant is held until the owner pulses done. The next search starts just
// after the last owner. The grant is presented both as a one-hot vector and
// as a binary index with valid.
// Optional feature: define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD
// cycles. When the macro is undefined, timeout is tied low.
module rr_resource_scheduler #(
  parameter  int N        = 8,
  parameter  int MAX_HOLD = 16,
  localparam int M        = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic [M-1:0] gnt_idx,
  output logic         gnt_valid,
  output logic         timeout
);

  localparam int unsigned NU = N;

  if (N < 1 || N > 64 || MAX_HOLD < 1) begin : g_param_check
    $error("rr_resource_scheduler: N must be 1..64 and MAX_HOLD >= 1");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_next;
  logic [N-1:0]   gnt_next;
  logic [M-1:0]   idx_next;
  logic           valid_next;
  logic [M-1:0]   ptr, ptr_next;
  logic [M-1:0]   wrap_idx;
  logic           pick_found;
  logic [M-1:0]   pick_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              timeout_next;
`endif

  // Rotating priority search: first set req bit at ptr, ptr+1, ..., wrapping at N.
  always_comb begin
    int unsigned cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NU) cand = cand - NU;
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = M'(cand);
      end
    end
  end

  // Pointer value after the current owner releases: owner+1, wrapping N-1 to 0.
  always_comb begin
    wrap_idx = (gnt_idx == M'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    idx_next   = gnt_idx;
    valid_next = gnt_valid;
    ptr_next   = ptr;
`ifdef ARB_TIMEOUT_EN
    hold_next    = hold_cnt;
    timeout_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = BUSY;
          gnt_next   = N'(1) << pick_idx;
          idx_next   = pick_idx;
          valid_next = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_next  = '0;
`endif
        end
      end
      BUSY: begin
        if (done) begin
          state_next = IDLE;
          gnt_next   = '0;
          idx_next   = '0;
          valid_next = 1'b0;
          ptr_next   = wrap_idx;
        end
`ifdef ARB_TIMEOUT_EN
        // The limit is checked one cycle early, so the grant lasts exactly MAX_HOLD cycles.
        else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          state_next   = IDLE;
          gnt_next     = '0;
          idx_next     = '0;
          valid_next   = 1'b0;
          ptr_next     = wrap_idx;
          timeout_next = 1'b1;
        end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
          hold_next = hold_cnt + 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      gnt       <= gnt_next;
      gnt_idx   <= idx_next;
      gnt_valid <= valid_next;
      ptr       <= ptr_next;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= hold_next;
      timeout   <= timeout_next;
`endif
    end
  end

`ifndef ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule
